// File: rtl/vc_test_src_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : vc_test_src_rr_arbiter_if
//  Brief   : Handshake bundle between test sources / sink and the
//            round-robin test-source arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
interface vc_test_src_rr_arbiter_if #(
    parameter int p_nreqs  = 2,
    parameter int p_msg_sz = 8,
    parameter int p_id_sz  = 1,
    parameter int p_cnt_sz = 16
);
    logic [p_nreqs-1:0]          in_val;
    logic [p_nreqs-1:0]          in_rdy;
    logic [p_nreqs*p_msg_sz-1:0] in_msg;
    logic [p_nreqs-1:0]          in_done;
    logic                        out_val;
    logic                        out_rdy;
    logic [p_msg_sz-1:0]         out_msg;
    logic [p_id_sz-1:0]          out_id;
    logic [p_cnt_sz-1:0]         xfer_cnt;
    logic                        done;

    // Harness side: sources and sink
    modport master (
        output in_val, in_msg, in_done, out_rdy,
        input  in_rdy, out_val, out_msg, out_id, xfer_cnt, done
    );

    // Arbiter side
    modport slave (
        input  in_val, in_msg, in_done, out_rdy,
        output in_rdy, out_val, out_msg, out_id, xfer_cnt, done
    );
endinterface
`default_nettype wire

// File: rtl/vc_test_src_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : vc_test_src_rr_arbiter
//  Brief   : Round-robin merge of p_nreqs val/rdy test-source streams into a
//            one-entry registered output buffer, tagging each message with
//            its source index and aggregating per-source done flags.
//  Rev     : 1.0  initial release
// ============================================================================
module vc_test_src_rr_arbiter #(
    parameter int p_nreqs  = 2,
    parameter int p_msg_sz = 8,
    parameter int p_id_sz  = 1,
    parameter int p_cnt_sz = 16
) (
    input  wire logic                clk,
    input  wire logic                reset,   // asynchronous, active low
    vc_test_src_rr_arbiter_if.slave  bus
);

    localparam logic [p_id_sz-1:0] c_last_idx = p_id_sz'(p_nreqs - 1);

    // Buffer / priority state
    logic                 full_q,  full_d;
    logic [p_msg_sz-1:0]  msg_q,   msg_d;
    logic [p_id_sz-1:0]   id_q,    id_d;
    logic [p_id_sz-1:0]   ptr_q,   ptr_d;
    logic [p_cnt_sz-1:0]  cnt_q,   cnt_d;

    // Arbitration results
    logic [p_nreqs-1:0]   grant;
    logic [p_id_sz-1:0]   grant_idx;
    logic                 grant_any;
    logic [p_msg_sz-1:0]  grant_msg;
    logic                 can_acc;
    logic                 in_xfer;
    logic                 out_xfer;

    // Buffer can take a new message when empty or when it is drained this
    // same cycle; this makes in_rdy combinationally depend on out_rdy.
    assign can_acc  = !full_q || bus.out_rdy;
    assign out_xfer = full_q && bus.out_rdy;
    assign in_xfer  = grant_any && can_acc;

    // Round-robin search: first valid source at or above ptr, otherwise the
    // first valid source below ptr (the wrap-around part of the search).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (!grant_any && bus.in_val[i] && (i >= int'(ptr_q))) begin
                grant[i]  = 1'b1;
                grant_idx = p_id_sz'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = 0; i < p_nreqs; i++) begin
            if (!grant_any && bus.in_val[i] && (i < int'(ptr_q))) begin
                grant[i]  = 1'b1;
                grant_idx = p_id_sz'(i);
                grant_any = 1'b1;
            end
        end
    end

    // Mux the granted source's message; other lanes are never looked at
    always_comb begin
        grant_msg = '0;
        for (int i = 0; i < p_nreqs; i++) begin
            if (grant[i]) begin
                grant_msg = bus.in_msg[i*p_msg_sz +: p_msg_sz];
            end
        end
    end

    // Next-state: drain on output transfer, reload (and rotate priority)
    // on input transfer; a simultaneous pair keeps the buffer full.
    always_comb begin
        full_d = full_q;
        msg_d  = msg_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (out_xfer) begin
            full_d = 1'b0;
        end
        if (in_xfer) begin
            full_d = 1'b1;
            msg_d  = grant_msg;
            id_d   = grant_idx;
            ptr_d  = (grant_idx == c_last_idx) ? '0 : grant_idx + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            msg_q  <= '0;
            id_q   <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            msg_q  <= msg_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.in_rdy   = grant & {p_nreqs{can_acc}};
    assign bus.out_val  = full_q;
    assign bus.out_msg  = msg_q;
    assign bus.out_id   = id_q;
    assign bus.xfer_cnt = cnt_q;
    assign bus.done     = (&bus.in_done) && !full_q && !(|bus.in_val);

endmodule
`default_nettype wire
